// File: rtl/prog_delay_timer.sv
// Programmable millisecond delay timer: target = BASE_MS + code*STEP_MS, done pulse on expiry.
// Optional macro PROG_DELAY_TIMER_RAND_CODE_EN takes the code from an internal 16-bit LFSR.
module prog_delay_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int CODE_W       = 4,
    parameter int BASE_MS      = 1000,
    parameter int STEP_MS      = 125,
    parameter int CNT_W        = 32,
    parameter bit AUTO_RELOAD  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cancel,
    input  logic [CODE_W-1:0] delay_code,
    output logic              busy,
    output logic              delay_done,
    output logic [CNT_W-1:0]  remaining_ms
);
    localparam int              PRE_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_MS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [PRE_W-1:0]   presc_q;
    logic [CNT_W-1:0]   ms_cnt_q;
    logic [CNT_W-1:0]   target_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               busy_q;
    logic               done_q;

    logic [CODE_W-1:0]  code_sel;
    logic [CNT_W-1:0]   target_d;
    logic [CNT_W-1:0]   ms_cnt_d;
    logic               tick_ms;
    logic               expire;

`ifdef PROG_DELAY_TIMER_RAND_CODE_EN
    // Free-running Fibonacci LFSR (taps 16,14,13,11); CODE_W must not exceed 16.
    logic [15:0] lfsr_q;
    logic        unused_delay_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign code_sel          = lfsr_q[CODE_W-1:0];
    assign unused_delay_code = ^delay_code;
`else
    assign code_sel = delay_code;
`endif

    assign target_d = CNT_W'(BASE_MS) + CNT_W'(code_sel) * CNT_W'(STEP_MS);
    assign tick_ms  = (presc_q == PRE_MAX);
    assign ms_cnt_d = ms_cnt_q + CNT_W'(1);
    assign expire   = tick_ms && (ms_cnt_d == target_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            ms_cnt_q    <= '0;
            target_q    <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        target_q    <= target_d;
                        remaining_q <= target_d;
                        presc_q     <= '0;
                        ms_cnt_q    <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    // Cancel has priority over expiry, so an aborted round never pulses.
                    if (cancel) begin
                        presc_q     <= '0;
                        ms_cnt_q    <= '0;
                        target_q    <= '0;
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (expire) begin
                        done_q   <= 1'b1;
                        presc_q  <= '0;
                        ms_cnt_q <= '0;
                        if (AUTO_RELOAD) begin
                            target_q    <= target_d;
                            remaining_q <= target_d;
                        end else begin
                            target_q    <= '0;
                            remaining_q <= '0;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else begin
                        presc_q <= tick_ms ? '0 : presc_q + PRE_W'(1);
                        if (tick_ms) begin
                            ms_cnt_q    <= ms_cnt_d;
                            remaining_q <= target_q - ms_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign delay_done   = done_q;
    assign remaining_ms = remaining_q;
endmodule
